// File: rtl/unified_mem_arbiter_pkg.sv
// Shared types and encodings for the unified instruction/data memory arbiter.
package unified_mem_arbiter_pkg;

  typedef enum logic [1:0] {
    ARB_IDLE = 2'd0,
    ARB_WAIT = 2'd1,
    ARB_ERR  = 2'd2
  } arb_state_t;

  typedef enum logic {
    OWN_FETCH = 1'b0,
    OWN_DATA  = 1'b1
  } owner_t;

  localparam logic [1:0] SZ_BYTE = 2'b00;
  localparam logic [1:0] SZ_HALF = 2'b01;
  localparam logic [1:0] SZ_WORD = 2'b10;

endpackage

// File: rtl/unified_mem_arbiter_mem_lane_align.sv
// Byte-lane steering for data accesses: byte enables, store-data replication,
// and alignment checking from the low address bits and access size.
module unified_mem_arbiter_mem_lane_align
  import unified_mem_arbiter_pkg::*;
(
  input  logic [1:0]  addr,
  input  logic [1:0]  size,
  input  logic [31:0] wdata,
  output logic [3:0]  be,
  output logic [31:0] wdata_rep,
  output logic        misaligned
);

  always_comb begin
    be         = 4'b0000;
    wdata_rep  = wdata;
    misaligned = 1'b0;
    case (size)
      SZ_BYTE: begin
        be        = 4'b0001 << addr;
        wdata_rep = {4{wdata[7:0]}};
      end
      SZ_HALF: begin
        be         = 4'b0011 << {addr[1], 1'b0};
        wdata_rep  = {2{wdata[15:0]}};
        misaligned = addr[0];
      end
      SZ_WORD: begin
        be         = 4'b1111;
        misaligned = (addr != 2'b00);
      end
      default: misaligned = 1'b1;
    endcase
  end

endmodule

// File: rtl/unified_mem_arbiter.sv
// Single-outstanding arbiter sharing one memory port between fetch and load/store.
// Optional build macro ARB_PERF_CNT_EN adds grant/stall performance counters.
module unified_mem_arbiter
  import unified_mem_arbiter_pkg::*;
#(
  parameter int STARVE_LIMIT = 4,
  parameter int CNT_W        = 4
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        flush,
  input  logic        f_req,
  input  logic [31:0] f_addr,
  output logic        f_gnt,
  output logic        f_rvalid,
  output logic [31:0] f_rdata,
  input  logic        d_req,
  input  logic        d_we,
  input  logic [31:0] d_addr,
  input  logic [31:0] d_wdata,
  input  logic [1:0]  d_size,
  output logic        d_gnt,
  output logic        d_rvalid,
  output logic [31:0] d_rdata,
  output logic        d_err,
  output logic        mem_req,
  input  logic        mem_ready,
  output logic        mem_we,
  output logic [31:0] mem_addr,
  output logic [3:0]  mem_be,
  output logic [31:0] mem_wdata,
  input  logic        mem_rvalid,
  input  logic [31:0] mem_rdata
`ifdef ARB_PERF_CNT_EN
  ,
  output logic [31:0] perf_f_gnt,
  output logic [31:0] perf_d_gnt,
  output logic [31:0] perf_f_stall
`endif
);

  localparam logic [CNT_W-1:0] LIMIT = CNT_W'(STARVE_LIMIT);

  arb_state_t       state_q, state_d;
  owner_t           owner_q, owner_d;
  logic             kill_q, kill_d;
  logic [CNT_W-1:0] starve_cnt_q, starve_cnt_d;

  logic [3:0]  d_be;
  logic [31:0] d_wdata_rep;
  logic        d_misaligned;
  logic        sel_data, sel_fetch;
  logic        unused_f_addr_bits;

  assign unused_f_addr_bits = ^f_addr[1:0];

  unified_mem_arbiter_mem_lane_align u_align (
    .addr       (d_addr[1:0]),
    .size       (d_size),
    .wdata      (d_wdata),
    .be         (d_be),
    .wdata_rep  (d_wdata_rep),
    .misaligned (d_misaligned)
  );

  // Arbitration is gated by reset so nothing leaks onto the bus while held in reset.
  assign sel_data  = reset && d_req && (!f_req || (starve_cnt_q != LIMIT));
  assign sel_fetch = reset && f_req && !sel_data;

  always_comb begin
    state_d      = state_q;
    owner_d      = owner_q;
    kill_d       = kill_q;
    starve_cnt_d = starve_cnt_q;
    mem_req      = 1'b0;
    mem_we       = 1'b0;
    mem_addr     = 32'h0;
    mem_be       = 4'b0000;
    mem_wdata    = 32'h0;
    f_gnt        = 1'b0;
    d_gnt        = 1'b0;
    f_rvalid     = 1'b0;
    f_rdata      = 32'h0;
    d_rvalid     = 1'b0;
    d_rdata      = 32'h0;
    d_err        = 1'b0;
    case (state_q)
      ARB_IDLE: begin
        if (sel_data && d_misaligned) begin
          d_gnt   = 1'b1;
          state_d = ARB_ERR;
        end else if (sel_data) begin
          mem_req   = 1'b1;
          mem_we    = d_we;
          mem_addr  = {d_addr[31:2], 2'b00};
          mem_be    = d_be;
          mem_wdata = d_we ? d_wdata_rep : 32'h0;
          if (mem_ready) begin
            d_gnt   = 1'b1;
            owner_d = OWN_DATA;
            state_d = ARB_WAIT;
          end
        end else if (sel_fetch) begin
          mem_req  = 1'b1;
          mem_addr = {f_addr[31:2], 2'b00};
          mem_be   = 4'b1111;
          if (mem_ready) begin
            f_gnt   = 1'b1;
            owner_d = OWN_FETCH;
            kill_d  = flush;
            state_d = ARB_WAIT;
          end
        end
      end
      ARB_WAIT: begin
        if (mem_rvalid) begin
          state_d = ARB_IDLE;
          kill_d  = 1'b0;
          if (owner_q == OWN_DATA) begin
            d_rvalid = 1'b1;
            d_rdata  = mem_rdata;
          end else if (!kill_q && !flush) begin
            f_rvalid = 1'b1;
            f_rdata  = mem_rdata;
          end
        end else if (flush && (owner_q == OWN_FETCH)) begin
          kill_d = 1'b1;
        end
      end
      ARB_ERR: begin
        d_rvalid = 1'b1;
        d_err    = 1'b1;
        state_d  = ARB_IDLE;
      end
      default: state_d = ARB_IDLE;
    endcase
    if (!f_req || f_gnt) begin
      starve_cnt_d = '0;
    end else if (d_gnt && (starve_cnt_q != LIMIT)) begin
      starve_cnt_d = starve_cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q      <= ARB_IDLE;
      owner_q      <= OWN_FETCH;
      kill_q       <= 1'b0;
      starve_cnt_q <= '0;
    end else begin
      state_q      <= state_d;
      owner_q      <= owner_d;
      kill_q       <= kill_d;
      starve_cnt_q <= starve_cnt_d;
    end
  end

`ifdef ARB_PERF_CNT_EN
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      perf_f_gnt   <= 32'h0;
      perf_d_gnt   <= 32'h0;
      perf_f_stall <= 32'h0;
    end else begin
      if (f_gnt)          perf_f_gnt   <= perf_f_gnt + 32'd1;
      if (d_gnt)          perf_d_gnt   <= perf_d_gnt + 32'd1;
      if (f_req && !f_gnt) perf_f_stall <= perf_f_stall + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_unified_mem_arbiter.sv
// Directed vector bench for unified_mem_arbiter plus starvation, flush and reset sequences.
module tb_unified_mem_arbiter;
  import unified_mem_arbiter_pkg::*;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        flush = 1'b0;
  logic        f_req = 1'b0;
  logic [31:0] f_addr = 32'h0;
  logic        f_gnt, f_rvalid;
  logic [31:0] f_rdata;
  logic        d_req = 1'b0, d_we = 1'b0;
  logic [31:0] d_addr = 32'h0, d_wdata = 32'h0;
  logic [1:0]  d_size = 2'b00;
  logic        d_gnt, d_rvalid, d_err;
  logic [31:0] d_rdata;
  logic        mem_req, mem_we;
  logic        mem_ready = 1'b0, mem_rvalid = 1'b0;
  logic [31:0] mem_addr, mem_wdata;
  logic [3:0]  mem_be;
  logic [31:0] mem_rdata = 32'h0;
`ifdef ARB_PERF_CNT_EN
  logic [31:0] perf_f_gnt, perf_d_gnt, perf_f_stall;
`endif

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  unified_mem_arbiter #(.STARVE_LIMIT(4), .CNT_W(4)) dut (
    .clk(clk), .reset(reset), .flush(flush),
    .f_req(f_req), .f_addr(f_addr), .f_gnt(f_gnt), .f_rvalid(f_rvalid), .f_rdata(f_rdata),
    .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata), .d_size(d_size),
    .d_gnt(d_gnt), .d_rvalid(d_rvalid), .d_rdata(d_rdata), .d_err(d_err),
    .mem_req(mem_req), .mem_ready(mem_ready), .mem_we(mem_we), .mem_addr(mem_addr),
    .mem_be(mem_be), .mem_wdata(mem_wdata), .mem_rvalid(mem_rvalid), .mem_rdata(mem_rdata)
`ifdef ARB_PERF_CNT_EN
    , .perf_f_gnt(perf_f_gnt), .perf_d_gnt(perf_d_gnt), .perf_f_stall(perf_f_stall)
`endif
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end else begin
      $display("ok   %s = 0x%08h", name, act);
    end
  endtask

  typedef struct {
    logic        f_req;
    logic [31:0] f_addr;
    logic        d_req;
    logic        d_we;
    logic [31:0] d_addr;
    logic [31:0] d_wdata;
    logic [1:0]  d_size;
    logic        mem_ready;
    logic [31:0] rdata;
    logic        e_mem_req;
    logic        e_mem_we;
    logic [31:0] e_addr;
    logic [3:0]  e_be;
    logic [31:0] e_wdata;
    logic        e_f_gnt;
    logic        e_d_gnt;
    logic        e_err;
  } vec_t;

  vec_t vecs [12];

  function automatic logic [11:0] all_outs();
    return {|mem_addr, |mem_be, |mem_wdata, mem_req, mem_we, f_gnt, d_gnt,
            f_rvalid, d_rvalid, d_err, |f_rdata, |d_rdata};
  endfunction

  initial begin
    // f_req f_addr d_req d_we d_addr d_wdata size rdy rdata | mreq mwe addr be wdata fg dg err
    vecs[0]  = '{1'b1, 32'h100, 1'b0, 1'b0, 32'h0,   32'h0,        SZ_BYTE, 1'b1, 32'h00000013,
                 1'b1, 1'b0, 32'h100, 4'hF, 32'h0,        1'b1, 1'b0, 1'b0};
    vecs[1]  = '{1'b0, 32'h0,   1'b1, 1'b1, 32'h203, 32'h000000AB, SZ_BYTE, 1'b1, 32'h0,
                 1'b1, 1'b1, 32'h200, 4'h8, 32'hABABABAB, 1'b0, 1'b1, 1'b0};
    vecs[2]  = '{1'b0, 32'h0,   1'b1, 1'b0, 32'h106, 32'h00000055, SZ_HALF, 1'b1, 32'hCAFEF00D,
                 1'b1, 1'b0, 32'h104, 4'hC, 32'h0,        1'b0, 1'b1, 1'b0};
    vecs[3]  = '{1'b0, 32'h0,   1'b1, 1'b1, 32'h102, 32'h1234BEEF, SZ_HALF, 1'b1, 32'h0,
                 1'b1, 1'b1, 32'h100, 4'hC, 32'hBEEFBEEF, 1'b0, 1'b1, 1'b0};
    vecs[4]  = '{1'b0, 32'h0,   1'b1, 1'b1, 32'h040, 32'hDEADBEEF, SZ_WORD, 1'b1, 32'h0,
                 1'b1, 1'b1, 32'h040, 4'hF, 32'hDEADBEEF, 1'b0, 1'b1, 1'b0};
    vecs[5]  = '{1'b0, 32'h0,   1'b1, 1'b0, 32'h301, 32'h0,        SZ_BYTE, 1'b1, 32'h11223344,
                 1'b1, 1'b0, 32'h300, 4'h2, 32'h0,        1'b0, 1'b1, 1'b0};
    vecs[6]  = '{1'b1, 32'h500, 1'b1, 1'b0, 32'h600, 32'h0,        SZ_WORD, 1'b1, 32'h00600600,
                 1'b1, 1'b0, 32'h600, 4'hF, 32'h0,        1'b0, 1'b1, 1'b0};
    vecs[7]  = '{1'b0, 32'h0,   1'b1, 1'b0, 32'h010, 32'h0,        SZ_WORD, 1'b0, 32'h0,
                 1'b1, 1'b0, 32'h010, 4'hF, 32'h0,        1'b0, 1'b0, 1'b0};
    vecs[8]  = '{1'b0, 32'h0,   1'b1, 1'b0, 32'h202, 32'h0,        SZ_WORD, 1'b1, 32'h0,
                 1'b0, 1'b0, 32'h0,   4'h0, 32'h0,        1'b0, 1'b1, 1'b1};
    vecs[9]  = '{1'b0, 32'h0,   1'b1, 1'b0, 32'h000, 32'h0,        2'b11,   1'b1, 32'h0,
                 1'b0, 1'b0, 32'h0,   4'h0, 32'h0,        1'b0, 1'b1, 1'b1};
    vecs[10] = '{1'b0, 32'h0,   1'b1, 1'b1, 32'h105, 32'h0000FFFF, SZ_HALF, 1'b1, 32'h0,
                 1'b0, 1'b0, 32'h0,   4'h0, 32'h0,        1'b0, 1'b1, 1'b1};
    vecs[11] = '{1'b1, 32'h204, 1'b0, 1'b0, 32'h0,   32'h0,        SZ_BYTE, 1'b0, 32'h0,
                 1'b1, 1'b0, 32'h204, 4'hF, 32'h0,        1'b0, 1'b0, 1'b0};

    // Reset with requests pending: every output must stay low.
    f_req = 1'b1; d_req = 1'b1; d_size = SZ_WORD; mem_ready = 1'b1;
    #2;
    chk("reset outputs", 32'(all_outs()), 32'h0);
    repeat (2) @(negedge clk);
    f_req = 1'b0; d_req = 1'b0;
    reset = 1'b1;
    mem_rdata = 32'hBAD0BAD0;

    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      f_req = vecs[i].f_req;  f_addr = vecs[i].f_addr;
      d_req = vecs[i].d_req;  d_we = vecs[i].d_we;  d_addr = vecs[i].d_addr;
      d_wdata = vecs[i].d_wdata;  d_size = vecs[i].d_size;  mem_ready = vecs[i].mem_ready;
      #1;
      chk($sformatf("v%0d mem_req", i),   32'(mem_req),   32'(vecs[i].e_mem_req));
      chk($sformatf("v%0d mem_we", i),    32'(mem_we),    32'(vecs[i].e_mem_we));
      chk($sformatf("v%0d mem_addr", i),  mem_addr,       vecs[i].e_addr);
      chk($sformatf("v%0d mem_be", i),    32'(mem_be),    32'(vecs[i].e_be));
      chk($sformatf("v%0d mem_wdata", i), mem_wdata,      vecs[i].e_wdata);
      chk($sformatf("v%0d gnt f/d", i),   32'({f_gnt, d_gnt}), 32'({vecs[i].e_f_gnt, vecs[i].e_d_gnt}));
      @(posedge clk);
      @(negedge clk);
      f_req = 1'b0; d_req = 1'b0;
      #1;
      if (vecs[i].e_err) begin
        chk($sformatf("v%0d err rsp", i), 32'({d_rvalid, d_err, f_rvalid, mem_req}), 32'b1100);
        chk($sformatf("v%0d err rdata", i), d_rdata, 32'h0);
      end else if (vecs[i].e_f_gnt || vecs[i].e_d_gnt) begin
        chk($sformatf("v%0d wait quiet", i), 32'({f_rvalid, d_rvalid, mem_req}), 32'b000);
        @(negedge clk);
        mem_rvalid = 1'b1; mem_rdata = vecs[i].rdata;
        #1;
        chk($sformatf("v%0d rvalid f/d", i), 32'({f_rvalid, d_rvalid, d_err}),
            32'({vecs[i].e_f_gnt, vecs[i].e_d_gnt, 1'b0}));
        chk($sformatf("v%0d rdata", i), vecs[i].e_f_gnt ? f_rdata : d_rdata, vecs[i].rdata);
        @(posedge clk);
        #1 mem_rvalid = 1'b0; mem_rdata = 32'hBAD0BAD0;
      end
    end

    // Both requesters held: data wins four times, then fetch is forced.
    @(negedge clk);
    f_req = 1'b1; f_addr = 32'h700; d_req = 1'b1; d_we = 1'b0; d_addr = 32'h800;
    d_size = SZ_WORD; mem_ready = 1'b1;
    for (int g = 0; g < 10; g++) begin
      #1;
      chk($sformatf("starve grant %0d f/d", g), 32'({f_gnt, d_gnt}),
          (g % 5 == 4) ? 32'b10 : 32'b01);
      @(posedge clk);
      @(negedge clk);
      mem_rvalid = 1'b1; mem_rdata = 32'(g);
      @(posedge clk);
      @(negedge clk);
      mem_rvalid = 1'b0;
    end
    f_req = 1'b0; d_req = 1'b0;

    // Flush while the fetch is in flight: response swallowed.
    @(negedge clk);
    f_req = 1'b1; f_addr = 32'h900;
    #1 chk("flush1 f_gnt", 32'(f_gnt), 32'h1);
    @(posedge clk); @(negedge clk);
    f_req = 1'b0; flush = 1'b1;
    @(posedge clk); @(negedge clk);
    flush = 1'b0; mem_rvalid = 1'b1; mem_rdata = 32'h00001234;
    #1 chk("flush1 f_rvalid", 32'(f_rvalid), 32'h0);
    @(posedge clk); @(negedge clk);
    mem_rvalid = 1'b0; f_req = 1'b1; f_addr = 32'h904;
    #1 chk("post-flush f_gnt", 32'(f_gnt), 32'h1);
    @(posedge clk); @(negedge clk);
    f_req = 1'b0; mem_rvalid = 1'b1; mem_rdata = 32'h00005678;
    #1 chk("post-flush f_rvalid/rdata", {f_rvalid, f_rdata[30:0]}, {1'b1, 31'h5678});
    @(posedge clk); @(negedge clk);
    mem_rvalid = 1'b0;

    // Flush coincident with the fetch grant.
    f_req = 1'b1; f_addr = 32'h908; flush = 1'b1;
    #1 chk("flush2 f_gnt", 32'(f_gnt), 32'h1);
    @(posedge clk); @(negedge clk);
    f_req = 1'b0; flush = 1'b0; mem_rvalid = 1'b1;
    #1 chk("flush2 f_rvalid", 32'(f_rvalid), 32'h0);
    @(posedge clk); @(negedge clk);
    mem_rvalid = 1'b0;

    // Flush does not disturb a data load.
    d_req = 1'b1; d_we = 1'b0; d_addr = 32'h880; d_size = SZ_WORD; flush = 1'b1;
    #1 chk("flush data d_gnt", 32'(d_gnt), 32'h1);
    @(posedge clk); @(negedge clk);
    d_req = 1'b0; mem_rvalid = 1'b1; mem_rdata = 32'h0000ABCD;
    #1 chk("flush data d_rvalid/rdata", {d_rvalid, d_rdata[30:0]}, {1'b1, 31'hABCD});
    @(posedge clk); @(negedge clk);
    mem_rvalid = 1'b0; flush = 1'b0;

    // Reset mid-transaction, then a stale response arrives.
    f_req = 1'b1; f_addr = 32'hA00;
    #1 chk("rst seq f_gnt", 32'(f_gnt), 32'h1);
    @(posedge clk); @(negedge clk);
    reset = 1'b0; d_req = 1'b1; d_addr = 32'hB00; d_size = SZ_WORD;
    #1 chk("mid reset outputs", 32'(all_outs()), 32'h0);
    @(posedge clk); @(negedge clk);
    reset = 1'b1; f_req = 1'b0; d_req = 1'b0; mem_rvalid = 1'b1; mem_rdata = 32'h77777777;
    #1 chk("stale rvalid f/d", 32'({f_rvalid, d_rvalid}), 32'h0);
    @(posedge clk); @(negedge clk);
    mem_rvalid = 1'b0;

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not complete");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/unified_mem_arbiter.md
Name: unified_mem_arbiter

Overview:
Shares one single-port memory bus between the fetch stage's instruction requests and the retire stage's load/store requests. Supports one outstanding transaction. Data has priority, with a starvation bound that protects fetch. Generates byte enables, replicates store data onto byte lanes, detects misalignment, and drops in-flight fetch responses on a control-flow flush.

Parameters:
STARVE_LIMIT, 4, max consecutive data grants while f_req is pending before fetch is forced (1..15)
CNT_W, 4, width of the starvation counter

Ports:
clk  input  1  clock
reset  input  1  asynchronous, active-low reset
flush  input  1  jump taken at retire; kill any in-flight fetch response
f_req  input  1  fetch request; held with f_addr stable until f_gnt
f_addr  input  32  fetch word address
f_gnt  output  1  fetch request accepted this cycle
f_rvalid  output  1  instruction word valid (1-cycle pulse)
f_rdata  output  32  instruction word
d_req  input  1  data request; held stable until d_gnt
d_we  input  1  1 = store, 0 = load
d_addr  input  32  data byte address
d_wdata  input  32  store data, right-aligned
d_size  input  2  00 byte, 01 half, 10 word
d_gnt  output  1  data request accepted
d_rvalid  output  1  load data or store acknowledge (1-cycle pulse)
d_rdata  output  32  raw memory word, not shifted
d_err  output  1  qualifies d_rvalid: misaligned access, not issued
mem_req  output  1  memory request
mem_ready  input  1  memory accepts request this cycle
mem_we  output  1  write strobe
mem_addr  output  32  word address ({addr[31:2],2'b00})
mem_be  output  4  byte enables
mem_wdata  output  32  lane-replicated store data
mem_rvalid  input  1  response or write acknowledge
mem_rdata  input  32  read data

Behaviour:
- Reset (asynchronous, active-low): state ARB_IDLE, starve_cnt 0, kill 0, error-pending 0. All outputs 0.
- FSM states: ARB_IDLE, ARB_WAIT, ARB_ERR.
- ARB_IDLE selection (combinational):
  - d_req only -> data.
  - f_req only -> fetch.
  - Both -> data, unless starve_cnt == STARVE_LIMIT, in which case fetch.
- Misaligned selected data request (half with addr[0]=1, or word with addr[1:0]!=0, or size 11):
  - mem_req stays 0; d_gnt=1 this cycle; go to ARB_ERR.
  - ARB_ERR lasts one cycle: d_rvalid=1, d_err=1, d_rdata=0; then ARB_IDLE.
- Aligned selection: mem_req=1 and fields are driven from the winner.
  - If mem_ready=1: the winner's gnt=1, the owner register is loaded, and the FSM goes to ARB_WAIT.
  - If mem_ready=0: the FSM stays in ARB_IDLE and re-arbitrates next cycle. Selection may change.
- Fetch requests drive mem_we=0 and mem_be=1111.
- Loads drive mem_be per size. Stores also replicate data: byte -> {4{b}}, half -> {2{h}}.
- Byte enables: byte -> 0001<<addr[1:0]; half -> 0011<<{addr[1],1'b0}; word -> 1111.
- ARB_WAIT: mem_req=0, no grants. On mem_rvalid, the owner's rvalid pulses in the same cycle with rdata passed through, then the FSM returns to ARB_IDLE. A new grant is possible the following cycle, so back-to-back throughput is 1 transaction per 2 cycles minimum.
- Flush handling:
  - flush in ARB_WAIT with owner=fetch, or flush in the same cycle as a fetch grant, sets kill.
  - The matching mem_rvalid is consumed with f_rvalid=0; kill clears.
  - flush does not affect data transactions or ARB_IDLE arbitration.
- starve_cnt:
  - Increments (saturating at STARVE_LIMIT) on each data grant while f_req=1.
  - Clears on a fetch grant or whenever f_req=0.
- mem_rvalid in ARB_IDLE or ARB_ERR is ignored, including stale responses after a mid-transaction reset.
- d_err=0 except in ARB_ERR.

Optional Feature:
ARB_PERF_CNT_EN:
- Defined: adds three 32-bit wrapping counters, cleared by reset, exposed on outputs perf_f_gnt, perf_d_gnt and perf_f_stall.
  - perf_f_gnt: fetch grants.
  - perf_d_gnt: data grants, including error grants.
  - perf_f_stall: cycles with f_req=1 and f_gnt=0.
- Undefined: counters and ports are absent. Functional behaviour is identical.

Decomposition:
- my_pkg additions: typedef enum arb_state_t {ARB_IDLE, ARB_WAIT, ARB_ERR}; typedef enum owner_t {OWN_FETCH, OWN_DATA}; constants SZ_BYTE=2'b00, SZ_HALF=2'b01, SZ_WORD=2'b10.
- One sub-module, mem_lane_align (combinational): inputs addr[1:0], size, wdata; outputs be, replicated wdata, misaligned flag.

Test Plan:
- f_req only, f_addr=0x100, mem_ready=1, mem_rvalid 2 cycles later with 0x00000013 -> f_gnt in cycle 0; f_rvalid=1 with f_rdata=0x00000013 in cycle 2; mem_addr=0x100, mem_be=1111.
- Store byte d_addr=0x203, d_wdata=0xAB -> mem_addr=0x200, mem_be=1000, mem_wdata=0xABABABAB, mem_we=1; d_rvalid on ack with d_err=0.
- f_req and d_req held continuously, STARVE_LIMIT=4 -> grant sequence D,D,D,D,F repeating; starve_cnt returns to 0 after each F.
- Load word d_addr=0x202 -> mem_req never asserted; d_gnt cycle 0; d_rvalid=1, d_err=1, d_rdata=0 in cycle 1.
- Fetch granted, flush pulsed in ARB_WAIT, mem_rvalid arrives -> no f_rvalid; next f_req granted normally.
- reset asserted in ARB_WAIT, released, then a stale mem_rvalid arrives -> no rvalid on either port; all outputs 0 during reset.
